hrange_dup_gen: RTL

// Parametrised streaming range generator with per-value repetition. Yields base, base+step, ...

---
 rtl/hrange_dup_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/hrange_dup_gen.sv
// Streaming signed range generator: emits base, base+step, ... while inside limit,
// repeating each value dup times with a repeat index, over a start/ready/valid/done handshake.
module hrange_dup_gen #(
    parameter int WIDTH = 32,
    parameter int DUP_W = 8
) (
    input  logic             _clock,
    input  logic             _reset,
    input  logic             _start,
    input  logic             _ready,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    input  logic [DUP_W-1:0] dup,
    output logic             _done,
    output logic             _valid,
    output logic [WIDTH-1:0] _0,
    output logic [DUP_W-1:0] _1
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] cur;
    logic signed [WIDTH-1:0] lim_q;
    logic signed [WIDTH-1:0] step_q;
    logic        [DUP_W-1:0] dup_q;
    logic        [DUP_W-1:0] rep;

    logic signed [WIDTH:0]   next_wide;
    logic                    next_ovf;
    logic        [DUP_W:0]   rep_inc;
    logic                    last_rep;

    // Direction is taken from the sign of step; a zero step never yields anything.
    function automatic logic in_range(input logic signed [WIDTH-1:0] v,
                                      input logic signed [WIDTH-1:0] lim,
                                      input logic signed [WIDTH-1:0] stp);
        if (stp == '0)
            return 1'b0;
        else if (stp[WIDTH-1])
            return v > lim;
        else
            return v < lim;
    endfunction

    always_comb begin
        // Successor is formed one bit wider so signed overflow is detectable
        // instead of silently wrapping back into range.
        next_wide = {cur[WIDTH-1], cur} + {step_q[WIDTH-1], step_q};
        next_ovf  = next_wide[WIDTH] ^ next_wide[WIDTH-1];
        rep_inc   = {1'b0, rep} + (DUP_W+1)'(1);
        last_rep  = rep_inc >= {1'b0, dup_q};
    end

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state  <= IDLE;
            cur    <= '0;
            lim_q  <= '0;
            step_q <= '0;
            dup_q  <= '0;
            rep    <= '0;
            _done  <= 1'b0;
            _valid <= 1'b0;
            _0     <= '0;
            _1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (_start) begin
                        lim_q  <= limit;
                        step_q <= step;
                        dup_q  <= dup;
                        cur    <= base;
                        rep    <= '0;
                        if (dup != '0 && in_range(base, limit, step)) begin
                            _valid <= 1'b1;
                            _done  <= 1'b0;
                            _0     <= base;
                            _1     <= '0;
                            state  <= RUN;
                        end else begin
                            _valid <= 1'b0;
                            _done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (_ready) begin
                        if (!last_rep) begin
                            rep <= rep_inc[DUP_W-1:0];
                            _1  <= rep_inc[DUP_W-1:0];
                        end else begin
                            rep <= '0;
                            if (next_ovf || !in_range(next_wide[WIDTH-1:0], lim_q, step_q)) begin
                                _valid <= 1'b0;
                                _done  <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                cur <= next_wide[WIDTH-1:0];
                                _0  <= next_wide[WIDTH-1:0];
                                _1  <= '0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
